// File: rtl/mul_div_unit_if.sv
// Handshake and data bundle between the execute stage and mul_div_unit.
// The execute stage drives the master side; the unit implements the slave side.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Define MUL_DIV_UNIT_DIV_EN to build the restoring divider; without it divide ops complete as no-ops.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   prod_fix;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic                 rneg_q, rneg_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     araw_q, araw_d;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic                 qbit;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
`endif

    // Signed ops iterate on magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // acc = {partial product, remaining multiplier bits}, shifted right once per step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MUL_DIV_UNIT_DIV_EN
    // acc = {partial remainder, dividend bits turning into quotient bits}.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, opb_q};
    assign qbit     = ~diff[WIDTH];
    assign div_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], qbit};
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            araw_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MUL_DIV_UNIT_DIV_EN
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            araw_q   <= araw_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MUL_DIV_UNIT_DIV_EN
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        araw_d   = araw_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    neg_d    = a_neg ^ b_neg;
                    acc_d    = {{WIDTH{1'b0}}, a_mag};
                    opb_d    = b_mag;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = RUN;
`ifdef MUL_DIV_UNIT_DIV_EN
                    rneg_d   = a_neg;
                    div0_d   = (bus.b == '0);
                    araw_d   = bus.a;
`else
                    if (bus.op[1]) begin
                        state_d = FIX;
                    end
`endif
                end else begin
                    // A start in the same cycle takes priority over HI/LO moves.
                    if (bus.mthi) begin
                        hi_d = bus.wdata;
                    end
                    if (bus.mtlo) begin
                        lo_d = bus.wdata;
                    end
                end
            end

            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                acc_d = mul_next;
`ifdef MUL_DIV_UNIT_DIV_EN
                if (is_div_q) begin
                    acc_d = div_next;
                end
`endif
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef MUL_DIV_UNIT_DIV_EN
                if (is_div_q) begin
                    if (div0_q) begin
                        hi_d = araw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
`else
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
